// File: rtl/e203_dtcm_arbt.sv
// Two-port round-robin arbiter in front of a single-port DTCM RAM with
// 1-cycle read latency, optional zero-fill after reset, and per-port response holding.
module e203_dtcm_arbt #(
  parameter int AW        = 13,
  parameter int DW        = 32,
  parameter int MW        = 4,
  parameter int INIT_ZERO = 1
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          p0_cmd_valid,
  output logic          p0_cmd_ready,
  input  logic          p0_cmd_read,
  input  logic [AW-1:0] p0_cmd_addr,
  input  logic [DW-1:0] p0_cmd_wdata,
  input  logic [MW-1:0] p0_cmd_wmask,
  output logic          p0_rsp_valid,
  input  logic          p0_rsp_ready,
  output logic [DW-1:0] p0_rsp_rdata,

  input  logic          p1_cmd_valid,
  output logic          p1_cmd_ready,
  input  logic          p1_cmd_read,
  input  logic [AW-1:0] p1_cmd_addr,
  input  logic [DW-1:0] p1_cmd_wdata,
  input  logic [MW-1:0] p1_cmd_wmask,
  output logic          p1_rsp_valid,
  input  logic          p1_rsp_ready,
  output logic [DW-1:0] p1_rsp_rdata,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,

  output logic          init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [1:0]    outst_q, outst_d;
  logic [1:0]    first_q, first_d;
  logic [1:0]    rd_q, rd_d;
  logic [DW-1:0] rdata_q [2];
  logic [DW-1:0] rdata_d [2];
  logic [DW-1:0] cur_rdata [2];

  logic [1:0]    cmd_valid, cmd_read, rsp_ready, elig, req, grant;
  logic [AW-1:0] cmd_addr  [2];
  logic [DW-1:0] cmd_wdata [2];
  logic [MW-1:0] cmd_wmask [2];

  assign cmd_valid    = {p1_cmd_valid, p0_cmd_valid};
  assign cmd_read     = {p1_cmd_read,  p0_cmd_read};
  assign rsp_ready    = {p1_rsp_ready, p0_rsp_ready};
  assign cmd_addr[0]  = p0_cmd_addr;
  assign cmd_addr[1]  = p1_cmd_addr;
  assign cmd_wdata[0] = p0_cmd_wdata;
  assign cmd_wdata[1] = p1_cmd_wdata;
  assign cmd_wmask[0] = p0_cmd_wmask;
  assign cmd_wmask[1] = p1_cmd_wmask;

  // A port may issue again in the same cycle its pending response is taken.
  assign elig = ~outst_q | rsp_ready;
  assign req  = cmd_valid & elig;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant    = '0;
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wem  = '0;
    ram_din  = '0;
    case (state_q)
      S_INIT: begin
        if (INIT_ZERO != 0) begin
          ram_cs   = ~rst;
          ram_we   = ~rst;
          ram_wem  = {MW{~rst}};
          ram_addr = cnt_q;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == {AW{1'b1}}) state_d = S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!rst) begin
          // last_q=1 means port 1 won most recently, so port 0 takes a tie.
          if (req == 2'b11) grant = last_q ? 2'b01 : 2'b10;
          else              grant = req;
        end
        for (int n = 0; n < 2; n++) begin
          if (grant[n]) begin
            ram_cs   = 1'b1;
            ram_we   = ~cmd_read[n];
            ram_addr = cmd_addr[n];
            ram_din  = cmd_wdata[n];
            ram_wem  = cmd_read[n] ? '0 : cmd_wmask[n];
          end
        end
        if (grant[0])      last_d = 1'b0;
        else if (grant[1]) last_d = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  // ram_dout is only meaningful in the first response cycle; capture it then.
  always_comb begin
    first_d = grant;
    for (int n = 0; n < 2; n++) begin
      cur_rdata[n] = rd_q[n] ? ram_dout : '0;
      rdata_d[n]   = first_q[n] ? cur_rdata[n] : rdata_q[n];
      outst_d[n]   = grant[n] | (outst_q[n] & ~rsp_ready[n]);
      rd_d[n]      = grant[n] ? cmd_read[n] : rd_q[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      outst_q <= '0;
      first_q <= '0;
      rd_q    <= '0;
      for (int n = 0; n < 2; n++) rdata_q[n] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      first_q <= first_d;
      rd_q    <= rd_d;
      for (int n = 0; n < 2; n++) rdata_q[n] <= rdata_d[n];
    end
  end

  assign p0_cmd_ready = grant[0];
  assign p1_cmd_ready = grant[1];
  assign p0_rsp_valid = outst_q[0] & ~rst;
  assign p1_rsp_valid = outst_q[1] & ~rst;
  assign p0_rsp_rdata = first_q[0] ? cur_rdata[0] : rdata_q[0];
  assign p1_rsp_rdata = first_q[1] ? cur_rdata[1] : rdata_q[1];
  assign init_done    = (state_q == S_RUN);

endmodule
